// File: rtl/capture_ram_pkg.sv
// Shared types and helpers for the capture RAM: FSM state encoding, write-mode
// constants and the pointer increment that wraps at an arbitrary depth.
package capture_ram_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Behavioural single-write-port RAM with a registered read-first read port.
// No reset: contents are initialised by the owner's clear sweep.
module ram_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_ram.sv
// Sample buffer between the front end and the readout layer: handshaked
// auto-incrementing writes, random-access reads and a one-word-per-cycle clear sweep.
module capture_ram
  import capture_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 5,
  parameter int DEPTH          = 1 << ADDR_WIDTH,
  parameter int ALMOST_FULL_TH = DEPTH - 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  MODE,
  input  logic                  CLR,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic [ADDR_WIDTH-1:0] WR_PTR,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic                  OVERRUN,
  output logic                  BUSY
);

  localparam int                    AF_TH      = (ALMOST_FULL_TH < 0) ? 0 : ALMOST_FULL_TH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   AF_C       = (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] idx, idx_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH:0]   count, count_n;
  logic                  overrun, overrun_n;
  logic                  rd_valid, rd_zero, rd_in_range;
  logic                  wr_fire, sweeping;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, core_rdata;

  assign sweeping    = (state == S_CLEAR);
  assign FULL        = (count == DEPTH_C);
  assign EMPTY       = (count == '0);
  assign ALMOST_FULL = (count >= AF_C);
  assign WR_READY    = (state == S_RUN) && !CLR && ((MODE == MODE_RING) || !FULL);
  assign wr_fire     = WR_VALID && WR_READY;
  assign rd_in_range = ({1'b0, RD_ADDR} < DEPTH_C);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wr_ptr_n  = wr_ptr;
    count_n   = count;
    overrun_n = overrun;
    if (CLR) begin
      state_n   = S_CLEAR;
      idx_n     = '0;
      wr_ptr_n  = '0;
      count_n   = '0;
      overrun_n = 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (idx == LAST_IDX) begin
            state_n = S_RUN;
            idx_n   = '0;
          end else begin
            idx_n = idx + ADDR_WIDTH'(1);
          end
        end
        S_RUN: begin
          if (wr_fire) begin
            wr_ptr_n = ADDR_WIDTH'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
            if (count < DEPTH_C) count_n = count + (ADDR_WIDTH+1)'(1);
            else                 overrun_n = 1'b1;
            if ((MODE == MODE_ONESHOT) && (count == LAST_COUNT)) state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          // Resuming in ring mode starts overwriting from the oldest word.
          if (MODE == MODE_RING) begin
            state_n  = S_RUN;
            wr_ptr_n = '0;
          end
        end
        default: state_n = S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_CLEAR;
      idx      <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
      overrun  <= overrun_n;
      rd_valid <= RD_EN;
      if (RD_EN) rd_zero <= !rd_in_range;
    end
  end

  // The sweep owns the write port while clearing; out-of-range reads are masked to zero.
  assign mem_we    = RST_N && (sweeping || wr_fire);
  assign mem_waddr = sweeping ? idx : wr_ptr;
  assign mem_wdata = sweeping ? '0 : WR_DATA;

  ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_core (
    .CLK  (CLK),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (RST_N && RD_EN && rd_in_range),
    .raddr(RD_ADDR),
    .rdata(core_rdata)
  );

  assign RD_DATA  = rd_zero ? '0 : core_rdata;
  assign RD_VALID = rd_valid;
  assign WR_PTR   = wr_ptr;
  assign COUNT    = count;
  assign OVERRUN  = overrun;
  assign BUSY     = sweeping;

endmodule

// File: tb/tb_capture_ram.sv
// Bench for capture_ram: a 32-deep instance checked every cycle against a
// behavioural buffer model, plus a 20-deep instance for non-power-of-two wrap.
module tb_capture_ram;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DA = 32;
  localparam int DB = 20;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          rst_n, mode, clr, wr_valid, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] rd_addr, wr_ptr;
  logic [AW:0]   count;
  logic          wr_ready, rd_valid, empty, full, almost_full, overrun, busy;

  logic          rst_n_b, mode_b, clr_b, wr_valid_b, rd_en_b;
  logic [DW-1:0] wr_data_b, rd_data_b;
  logic [AW-1:0] rd_addr_b, wr_ptr_b;
  logic [AW:0]   count_b;
  logic          wr_ready_b, rd_valid_b, empty_b, full_b, almost_full_b, overrun_b, busy_b;

  capture_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut_a (
    .CLK(CLK), .RST_N(rst_n), .MODE(mode), .CLR(clr),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_DATA(wr_data),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .WR_PTR(wr_ptr), .COUNT(count), .EMPTY(empty), .FULL(full),
    .ALMOST_FULL(almost_full), .OVERRUN(overrun), .BUSY(busy)
  );

  capture_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DB)) dut_b (
    .CLK(CLK), .RST_N(rst_n_b), .MODE(mode_b), .CLR(clr_b),
    .WR_VALID(wr_valid_b), .WR_READY(wr_ready_b), .WR_DATA(wr_data_b),
    .RD_EN(rd_en_b), .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b), .RD_VALID(rd_valid_b),
    .WR_PTR(wr_ptr_b), .COUNT(count_b), .EMPTY(empty_b), .FULL(full_b),
    .ALMOST_FULL(almost_full_b), .OVERRUN(overrun_b), .BUSY(busy_b)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t os_vecs[3];
  rd_vec_t ring_vecs[3];

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents plus fill level, pointer and remaining sweep words.
  logic [DW-1:0] m_mem [DA];
  int            m_ptr, m_count, m_sweep;
  bit            m_ovr, m_hold, m_rd_valid, live;
  logic [DW-1:0] m_rd_data;
  logic          s_ready, s_busy, s_ready_b;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit modelReady();
    return (m_sweep == 0) && !m_hold && !clr && (mode || (m_count < DA));
  endfunction

  task automatic modelStep();
    bit rdy;
    rdy = modelReady();
    if (!rst_n) begin
      m_ptr = 0; m_count = 0; m_ovr = 0; m_hold = 0; m_sweep = DA;
      m_rd_valid = 0; m_rd_data = '0;
      return;
    end
    if (rd_en) begin
      m_rd_valid = 1;
      m_rd_data  = (int'(rd_addr) < DA) ? m_mem[rd_addr] : '0;
    end else begin
      m_rd_valid = 0;
    end
    if (clr) begin
      if (m_sweep > 0) m_mem[DA - m_sweep] = '0;
      m_sweep = DA; m_ptr = 0; m_count = 0; m_ovr = 0; m_hold = 0;
    end else if (m_sweep > 0) begin
      m_mem[DA - m_sweep] = '0;
      m_sweep--;
    end else if (m_hold) begin
      if (mode) begin
        m_hold = 0;
        m_ptr  = 0;
      end
    end else if (wr_valid && rdy) begin
      m_mem[m_ptr] = wr_data;
      m_ptr = (m_ptr + 1) % DA;
      if (m_count == DA) m_ovr = 1;
      else               m_count++;
      if (!mode && m_count == DA) m_hold = 1;
    end
  endtask

  task automatic checkAll();
    checkOutput("wr_ready",    wr_ready,    modelReady());
    checkOutput("busy",        busy,        m_sweep > 0);
    checkOutput("count",       count,       m_count);
    checkOutput("empty",       empty,       m_count == 0);
    checkOutput("full",        full,        m_count == DA);
    checkOutput("almost_full", almost_full, m_count >= DA - 4);
    checkOutput("overrun",     overrun,     m_ovr);
    checkOutput("wr_ptr",      wr_ptr,      m_ptr);
    checkOutput("rd_valid",    rd_valid,    m_rd_valid);
    checkOutput("rd_data",     rd_data,     m_rd_data);
  endtask

  // One clock: inputs are already driven; sample, check, advance model, then clock.
  task automatic applyStimulus();
    #1;
    s_ready   = wr_ready;
    s_busy    = busy;
    s_ready_b = wr_ready_b;
    if (live) checkAll();
    modelStep();
    if (!rst_n) live = 1;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic writeA(input logic [DW-1:0] data);
    wr_valid = 1'b1;
    wr_data  = data;
    applyStimulus();
    wr_valid = 1'b0;
  endtask

  task automatic readA(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = addr;
    applyStimulus();
    rd_en   = 1'b0;
    checkOutput(name, rd_data, exp);
    checkOutput("read_valid", rd_valid, 1);
  endtask

  task automatic clearA();
    clr      = 1'b1;
    wr_valid = 1'b0;
    applyStimulus();
    clr = 1'b0;
    repeat (DA) applyStimulus();
    checkOutput("sweep_done", busy, 0);
  endtask

  task automatic cycleB();
    applyStimulus();
  endtask

  initial begin
    int busy_cycles;
    int accept_cycle;

    os_vecs[0]   = '{addr: 5'd5,  exp: 16'h0006};
    os_vecs[1]   = '{addr: 5'd0,  exp: 16'h0001};
    os_vecs[2]   = '{addr: 5'd31, exp: 16'h0020};
    ring_vecs[0] = '{addr: 5'd0,  exp: 16'h0120};
    ring_vecs[1] = '{addr: 5'd7,  exp: 16'h0127};
    ring_vecs[2] = '{addr: 5'd8,  exp: 16'h0108};

    for (int i = 0; i < DA; i++) m_mem[i] = 'x;
    live = 0;
    rst_n = 0; mode = 0; clr = 1; wr_valid = 1; wr_data = '0; rd_en = 1; rd_addr = '0;
    rst_n_b = 0; mode_b = 0; clr_b = 0; wr_valid_b = 0; wr_data_b = '0; rd_en_b = 0; rd_addr_b = '0;

    $display("[TB] reset");
    repeat (3) applyStimulus();
    checkOutput("rst_busy",     busy,     1);
    checkOutput("rst_wr_ready", wr_ready, 0);
    checkOutput("rst_empty",    empty,    1);
    checkOutput("rst_full",     full,     0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_data",  rd_data,  0);
    checkOutput("rst_b_busy",   busy_b,   1);

    $display("[TB] power-up sweep with write pending");
    rst_n = 1; rst_n_b = 1; clr = 0; rd_en = 0;
    wr_valid = 1; wr_data = 16'h0001;
    busy_cycles = 0; accept_cycle = 0;
    for (int i = 0; i < 100; i++) begin
      rd_en = (i >= 1); rd_addr = '0;
      applyStimulus();
      if (s_busy) busy_cycles++;
      if (s_ready) begin
        accept_cycle = i + 1;
        break;
      end
    end
    wr_valid = 0; rd_en = 0;
    checkOutput("busy_len",       busy_cycles,  32);
    checkOutput("first_accept",   accept_cycle, 33);
    checkOutput("pre_write_read", rd_data,      0);

    $display("[TB] one-shot fill");
    for (int k = 2; k <= 33; k++) begin
      wr_valid = 1; wr_data = DW'(k);
      applyStimulus();
      checkOutput("os_count", count, (k > 32) ? 32 : k);
      checkOutput("os_af",    almost_full, k >= 28);
    end
    checkOutput("os_full",  full,     1);
    checkOutput("os_ready", wr_ready, 0);
    wr_valid = 0;
    foreach (os_vecs[i]) readA(os_vecs[i].addr, os_vecs[i].exp, "os_read");

    $display("[TB] hold to ring");
    mode = 1;
    applyStimulus();
    checkOutput("hold_exit_ptr",   wr_ptr,   0);
    checkOutput("hold_exit_ready", wr_ready, 1);
    writeA(16'h0BBB);
    checkOutput("hold_ring_ovr", overrun, 1);
    readA(5'd0, 16'h0BBB, "hold_ring_read");

    $display("[TB] ring fill from empty");
    clearA();
    checkOutput("clr_ovr", overrun, 0);
    for (int k = 0; k < 40; k++) begin
      writeA(DW'(16'h0100 + k));
      checkOutput("ring_count", count, (k + 1 > 32) ? 32 : k + 1);
      checkOutput("ring_ovr",   overrun, (k + 1) >= 33);
    end
    checkOutput("ring_ptr", wr_ptr, 8);
    foreach (ring_vecs[i]) readA(ring_vecs[i].addr, ring_vecs[i].exp, "ring_read");

    $display("[TB] read-first collision");
    clearA();
    mode = 0;
    for (int k = 0; k < DA; k++) writeA((k == 3) ? 16'hAAAA : DW'($urandom));
    mode = 1;
    applyStimulus();
    for (int k = 0; k < 3; k++) writeA(DW'($urandom));
    wr_valid = 1; wr_data = 16'h5555; rd_en = 1; rd_addr = 5'd3;
    applyStimulus();
    wr_valid = 0; rd_en = 0;
    checkOutput("rf_old",   rd_data,  16'hAAAA);
    checkOutput("rf_valid", rd_valid, 1);
    readA(5'd3, 16'h5555, "rf_new");
    checkOutput("pre_clr_ovr", overrun, 1);

    $display("[TB] clear beats write, reset restarts sweep");
    clr = 1; wr_valid = 1; wr_data = 16'hDEAD;
    applyStimulus();
    clr = 0; wr_valid = 0;
    checkOutput("clr_ready_full", s_ready, 0);
    checkOutput("clr_ovr_zero",   overrun, 0);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      applyStimulus();
    end
    checkOutput("sweep_end", busy, 0);
    mode = 0;
    for (int k = 0; k < 10; k++) writeA(DW'($urandom));
    checkOutput("mid_count", count, 10);
    clr = 1; wr_valid = 1; wr_data = 16'hBEEF;
    applyStimulus();
    clr = 0; wr_valid = 0;
    checkOutput("clr_ready_mid", s_ready, 0);
    checkOutput("clr_count",     count,   0);
    checkOutput("clr_busy",      busy,    1);
    for (int i = 0; i < 11; i++) applyStimulus();
    rst_n = 0;
    applyStimulus();
    rst_n = 1;
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus();
      if (!s_busy) break;
      busy_cycles++;
    end
    checkOutput("rst_sweep_len", busy_cycles, 32);

    $display("[TB] depth-20 ring wrap");
    mode_b = 1;
    for (int k = 1; k <= 21; k++) begin
      wr_valid_b = 1; wr_data_b = DW'(16'h0200 + k - 1);
      cycleB();
      checkOutput("b_ready", s_ready_b, 1);
      checkOutput("b_ptr",   wr_ptr_b,  k % DB);
    end
    wr_valid_b = 0;
    checkOutput("b_count", count_b,   20);
    checkOutput("b_full",  full_b,    1);
    checkOutput("b_ovr",   overrun_b, 1);
    rd_en_b = 1; rd_addr_b = 5'd0;
    cycleB();
    checkOutput("b_read0", rd_data_b, 16'h0214);
    rd_addr_b = 5'd25;
    cycleB();
    checkOutput("b_read25",       rd_data_b,  0);
    checkOutput("b_read25_valid", rd_valid_b, 1);
    rd_addr_b = 5'd19;
    cycleB();
    checkOutput("b_read19", rd_data_b, 16'h0213);
    rd_en_b = 0;
    cycleB();
    checkOutput("b_idle_valid", rd_valid_b, 0);
    checkOutput("b_idle_hold",  rd_data_b,  16'h0213);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      clr      = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      wr_valid = ($urandom_range(0, 9) < 7);
      wr_data  = DW'($urandom);
      rd_en    = $urandom_range(0, 1) == 1;
      rd_addr  = AW'($urandom_range(0, DA - 1));
      applyStimulus();
    end
    rst_n = 1; clr = 0; wr_valid = 0; rd_en = 0;
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_ram.md
Name: capture_ram

Overview:
- Parametrised successor to the 16-bit single-port capture RAM.
- Data width, depth and write mode are configurable.
- Writes use a valid/ready handshake into an auto-incrementing write pointer.
- Reads are random-access. Fill level is reported as count, full and empty.
- Clear is a hardware sweep, one word per cycle, so no DEPTH-wide parallel reset is needed.
- Sits between the spike/sample front end and the readout/SPI layer as the sample buffer.

Parameters:
- DATA_WIDTH, 16: word width in bits.
- ADDR_WIDTH, 5: address/pointer width in bits.
- DEPTH, 1<<ADDR_WIDTH: number of words. Legal range 2..(1<<ADDR_WIDTH); need not be a power of two.
- ALMOST_FULL_TH, DEPTH-4: COUNT level at or above which ALMOST_FULL asserts.

Ports:
- CLK, in, 1: clock; everything is on the rising edge.
- RST_N, in, 1: synchronous active-low reset.
- MODE, in, 1: 0 = one-shot (stop at full), 1 = ring (wrap and overwrite).
- CLR, in, 1: start a clear sweep (level, sampled each cycle).
- WR_VALID, in, 1: write request.
- WR_READY, out, 1: write accepted this cycle when WR_VALID && WR_READY.
- WR_DATA, in, DATA_WIDTH: write data.
- RD_EN, in, 1: read request.
- RD_ADDR, in, ADDR_WIDTH: read address.
- RD_DATA, out, DATA_WIDTH: read data.
- RD_VALID, out, 1: RD_DATA valid; asserts one cycle after RD_EN.
- WR_PTR, out, ADDR_WIDTH: next write address.
- COUNT, out, ADDR_WIDTH+1: words written since the last clear, saturating at DEPTH.
- EMPTY, out, 1: COUNT==0.
- FULL, out, 1: COUNT==DEPTH.
- ALMOST_FULL, out, 1: COUNT>=ALMOST_FULL_TH.
- OVERRUN, out, 1: sticky; a ring-mode write overwrote unread-since-clear data.
- BUSY, out, 1: clear sweep in progress.

Behaviour:
- Reset (RST_N=0 at an edge):
  - WR_PTR=0, COUNT=0, OVERRUN=0, RD_DATA=0, RD_VALID=0, sweep index=0.
  - State goes to S_CLEAR.
  - Registered outputs observed during reset: BUSY=1, WR_READY=0, EMPTY=1, FULL=0.
- Reset overrides CLR, writes and reads. Reset during a sweep restarts the sweep at index 0.
- FSM states: S_CLEAR, S_RUN, S_HOLD.
  - S_CLEAR: write 0 to address idx, then idx++. After writing idx==DEPTH-1, go to S_RUN. Lasts exactly DEPTH cycles; BUSY=1 throughout.
  - S_RUN: accept writes.
    - Accepted write: mem[WR_PTR]<=WR_DATA.
    - WR_PTR increments and wraps DEPTH-1 -> 0 (explicit compare, not modulo 2^ADDR_WIDTH).
    - COUNT increments when <DEPTH.
    - In one-shot mode, the write that makes COUNT==DEPTH moves the FSM to S_HOLD.
    - In ring mode with FULL, each accepted write sets OVERRUN=1 and COUNT stays at DEPTH.
  - S_HOLD: WR_READY=0; writes are ignored. If MODE becomes 1, return to S_RUN next cycle with WR_PTR=0 (oldest word).
- Any state with CLR=1 and RST_N=1:
  - Next state is S_CLEAR with idx=0; WR_PTR, COUNT and OVERRUN are zeroed.
  - CLR held high keeps restarting the sweep.
  - CLR in the same cycle as a valid write: CLR wins and the write is dropped, because WR_READY is combinationally 0 when CLR=1.
- WR_READY = (state==S_RUN) && !CLR && (MODE || !FULL).
- MODE is sampled every cycle. Changing ring->one-shot while FULL stops writing immediately.
- Read:
  - RD_EN at cycle t gives RD_DATA=mem[RD_ADDR] and RD_VALID=1 at t+1. Reads are read-first: a same-address write in cycle t returns the old word.
  - RD_ADDR>=DEPTH returns 0 with RD_VALID=1.
  - Reads during S_CLEAR are legal and return the current (partially cleared) contents.
  - RD_EN=0 gives RD_VALID=0 next cycle; RD_DATA holds its last value.
- Flags (EMPTY/FULL/ALMOST_FULL) are combinational from registered COUNT.

Decomposition:
- Package capture_ram_pkg:
  - State encoding S_CLEAR=2'd0, S_RUN=2'd1, S_HOLD=2'd2.
  - MODE_ONESHOT=1'b0, MODE_RING=1'b1.
  - Function ptr_inc(ptr, depth) for wrap-at-DEPTH.
- One sub-module, ram_core (DATA_WIDTH, ADDR_WIDTH, DEPTH):
  - Behavioural array with one write port and one registered read-first read port, no reset.
  - The top multiplexes the write port between the sweep (data 0, addr idx) and the user write.

Test Plan:
- Release RST_N; hold WR_VALID=1 -> BUSY=1 for exactly DEPTH=32 cycles, WR_READY=0 throughout; first accepted write at cycle 33; every read before any write returns 0.
- One-shot: write 0x0001..0x0020 back-to-back -> COUNT 1..32, ALMOST_FULL from COUNT=28, FULL at write 32, WR_READY=0 after; 33rd value is not stored; reading addr 5 returns 0x0006.
- Ring mode: write 40 words 0x0100+i -> COUNT stays 32, OVERRUN=1 from write 33, WR_PTR=8; addr 0 holds 0x0120, addr 7 holds 0x0127, addr 8 holds 0x0108.
- Same cycle write and read to addr 3 holding 0xAAAA, writing 0x5555 -> RD_DATA=0xAAAA at t+1; a re-read gives 0x5555.
- CLR asserted with WR_VALID mid-fill (COUNT=10) -> write dropped, COUNT=0, OVERRUN=0, BUSY=32 cycles; RST_N pulsed low at sweep cycle 12 -> sweep restarts, BUSY lasts 32 cycles from release.
- DEPTH=20, ADDR_WIDTH=5, ring mode: 21 writes -> WR_PTR wraps 19->0->1; RD_ADDR=25 returns 0 with RD_VALID=1.
